// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the memory-stage handshake and the SRAM responder FSM.
// Also holds the size/alignment helper used at request acceptance.
package dbus_sram_responder_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dbus_rsp_state_t;

   function automatic logic is_aligned(input logic [2:0] lo, input msize_t size);
      case (size)
         MSIZE1:  return 1'b1;
         MSIZE2:  return ~lo[0];
         MSIZE4:  return (lo[1:0] == 2'b00);
         default: return (lo == 3'b000);
      endcase
   endfunction

endpackage

// File: rtl/dbus_sram_responder_word_ram.sv
// 64-bit word storage with a combinational read port and a byte-enable write port.
// Contents are deliberately not reset so the array maps onto block RAM.
module dbus_word_ram #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_idx,
   output logic [63:0]   rd_data,
   input  logic          we,
   input  logic [AW-1:0] wr_idx,
   input  logic [7:0]    wr_be,
   input  logic [63:0]   wr_data
);

   logic [63:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: one load/store at a time, fixed injected latency, sticky error flag.
//  state | meaning
//  IDLE  | waiting for dreq.valid; request latched and decoded on acceptance
//  WAIT  | counting down LATENCY; valid dropping here abandons the request
//  RESP  | addr_ok/data_ok high for one cycle; stores commit on the closing edge
module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int unsigned LATENCY     = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       err
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  LAT   = 4'(LATENCY);

   dbus_rsp_state_t state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q;
   logic [7:0]      strobe_q;
   logic [63:0]     wdata_q;
   logic            wr_q, ok_q;
   logic [63:0]     data_q, data_d;
   logic            err_q;

   logic            accept, abort;
   logic [AW-1:0]   req_idx, rd_idx;
   logic            req_ok, cur_ok, cur_wr;
   logic [63:0]     rd_word;
   logic            ram_we;

   assign req_idx = AW'((dreq.addr - BASE_ADDR) >> 3);
   assign req_ok  = (dreq.addr >= BASE_ADDR) && (dreq.addr < LIMIT)
                    && is_aligned(dreq.addr[2:0], dreq.size);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dreq.valid) begin
               accept  = 1'b1;
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (!dreq.valid) begin
               abort   = 1'b1;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RESP;
            end
         end
         RESP: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // With zero latency RESP is entered on the accepting edge, so the live request feeds the read.
   assign cur_ok = accept ? req_ok : ok_q;
   assign cur_wr = accept ? (|dreq.strobe) : wr_q;
   assign rd_idx = accept ? req_idx : idx_q;
   assign data_d = ((state_d == RESP) && cur_ok && !cur_wr) ? rd_word : 64'd0;
   assign ram_we = (state_q == RESP) && wr_q && ok_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         strobe_q <= 8'd0;
         wdata_q  <= 64'd0;
         wr_q     <= 1'b0;
         ok_q     <= 1'b0;
         data_q   <= 64'd0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_q | (accept && !req_ok) | abort;
         if (accept) begin
            idx_q    <= req_idx;
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
            wr_q     <= |dreq.strobe;
            ok_q     <= req_ok;
         end
      end
   end

   dbus_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .rd_idx  (rd_idx),
      .rd_data (rd_word),
      .we      (ram_we),
      .wr_idx  (idx_q),
      .wr_be   (strobe_q),
      .wr_data (wdata_q)
   );

   always_comb begin
      dresp         = '0;
      dresp.addr_ok = (state_q == RESP);
      dresp.data_ok = (state_q == RESP);
      dresp.data    = data_q;
   end

   assign err = err_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder at latencies 1, 0 and 3 with a response scoreboard.
module tb_dbus_sram_responder;
   import dbus_sram_responder_pkg::*;

   logic       clk = 1'b0;
   logic       resetn;
   dbus_req_t  req  [3];
   dbus_resp_t resp [3];
   logic       err  [3];

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int          d;
      logic [63:0] data;
      bit          chk_data;
      int          edges;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   dbus_sram_responder #(.LATENCY(1)) u_lat1 (
      .clk(clk), .resetn(resetn), .dreq(req[0]), .dresp(resp[0]), .err(err[0]));
   dbus_sram_responder #(.LATENCY(0)) u_lat0 (
      .clk(clk), .resetn(resetn), .dreq(req[1]), .dresp(resp[1]), .err(err[1]));
   dbus_sram_responder #(.LATENCY(3)) u_lat3 (
      .clk(clk), .resetn(resetn), .dreq(req[2]), .dresp(resp[2]), .err(err[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, expect data_ok after 'edges' rising edges, optionally drop valid in RESP.
   task automatic txn(input string tag, input int d, input logic [63:0] a, input msize_t sz,
                      input logic [7:0] stb, input logic [63:0] wd, input bit chk_data,
                      input logic [63:0] exp_data, input int edges, input bit drop);
      exp_t e;
      int   k;
      bit   got;
      sb_q.push_back('{d: d, data: exp_data, chk_data: chk_data, edges: edges});
      req[d].valid  = 1'b1;
      req[d].addr   = a;
      req[d].size   = sz;
      req[d].strobe = stb;
      req[d].data   = wd;
      got = 1'b0;
      k   = 0;
      while (!got && k < 24) begin
         @(posedge clk); #1;
         k++;
         got = resp[d].data_ok;
      end
      e = sb_q.pop_front();
      chk({tag, "_seen"}, 64'(got), 64'd1);
      chk({tag, "_lat"}, 64'(k), 64'(e.edges));
      if (got) begin
         chk({tag, "_addr_ok"}, 64'(resp[e.d].addr_ok), 64'd1);
         if (e.chk_data) chk({tag, "_data"}, resp[e.d].data, e.data);
      end
      if (drop) begin
         req[d].valid = 1'b0;
         @(posedge clk); #1;
         chk({tag, "_single"}, 64'(resp[d].data_ok), 64'd0);
         chk({tag, "_idle_data"}, resp[d].data, 64'd0);
      end
   endtask

   initial begin
      bit any_ok;
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) req[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_addr_ok", 64'(resp[i].addr_ok), 64'd0);
         chk("rst_data_ok", 64'(resp[i].data_ok), 64'd0);
         chk("rst_data", resp[i].data, 64'd0);
         chk("rst_err", 64'(err[i]), 64'd0);
      end
      resetn = 1'b1;
      @(posedge clk); #1;

      // latency 1: full store, load, byte merge
      txn("l1_st",  0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788, 0, 64'd0, 2, 1);
      txn("l1_ld",  0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1, 64'h1122334455667788, 2, 1);
      txn("l1_stb", 0, 64'h8000_0013, MSIZE1, 8'h08, 64'h00000000AB000000, 0, 64'd0, 2, 1);
      txn("l1_ldb", 0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1, 64'h11223344AB667788, 2, 1);
      chk("l1_err_clean", 64'(err[0]), 64'd0);
      txn("l1_st_top", 0, 64'h8000_7FF8, MSIZE8, 8'hFF, 64'hCAFEF00D12345678, 0, 64'd0, 2, 1);
      txn("l1_oor_ld", 0, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 1, 64'd0, 2, 1);
      chk("l1_err_oor", 64'(err[0]), 64'd1);
      txn("l1_oor_st", 0, 64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'hBADBADBADBADBAD0, 1, 64'd0, 2, 1);
      txn("l1_oor_hi", 0, 64'h8000_8000, MSIZE8, 8'h00, 64'd0, 1, 64'd0, 2, 1);
      txn("l1_top_ld", 0, 64'h8000_7FF8, MSIZE8, 8'h00, 64'd0, 1, 64'hCAFEF00D12345678, 2, 1);

      // latency 0: back-to-back loads, misaligned accesses
      txn("l0_st0", 1, 64'h8000_0000, MSIZE8, 8'hFF, 64'hA5A500005A5AFFFF, 0, 64'd0, 1, 1);
      txn("l0_st1", 1, 64'h8000_0008, MSIZE8, 8'hFF, 64'h0102030405060708, 0, 64'd0, 1, 1);
      txn("l0_ld0", 1, 64'h8000_0000, MSIZE4, 8'h00, 64'd0, 1, 64'hA5A500005A5AFFFF, 1, 0);
      txn("l0_ld1", 1, 64'h8000_0008, MSIZE2, 8'h00, 64'd0, 1, 64'h0102030405060708, 2, 1);
      chk("l0_err_clean", 64'(err[1]), 64'd0);
      txn("l0_mis_ld", 1, 64'h8000_0002, MSIZE4, 8'h00, 64'd0, 1, 64'd0, 1, 1);
      chk("l0_err_mis", 64'(err[1]), 64'd1);
      txn("l0_mis_st", 1, 64'h8000_0002, MSIZE4, 8'h3C, 64'h0000FFFFFFFF0000, 1, 64'd0, 1, 1);
      txn("l0_unchanged", 1, 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1, 64'hA5A500005A5AFFFF, 1, 1);

      // latency 3: normal pair, then a store abandoned in its second WAIT cycle
      txn("l3_st", 2, 64'h8000_0020, MSIZE8, 8'hFF, 64'hDEADBEEF0BADF00D, 0, 64'd0, 4, 1);
      txn("l3_ld", 2, 64'h8000_0020, MSIZE8, 8'h00, 64'd0, 1, 64'hDEADBEEF0BADF00D, 4, 1);
      chk("l3_err_clean", 64'(err[2]), 64'd0);
      req[2].valid  = 1'b1;
      req[2].addr   = 64'h8000_0020;
      req[2].size   = MSIZE8;
      req[2].strobe = 8'hFF;
      req[2].data   = 64'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req[2].valid = 1'b0;
      any_ok = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         any_ok = any_ok | resp[2].data_ok;
      end
      chk("l3_abort_no_resp", 64'(any_ok), 64'd0);
      chk("l3_abort_err", 64'(err[2]), 64'd1);
      txn("l3_after_abort", 2, 64'h8000_0020, MSIZE8, 8'h00, 64'd0, 1, 64'hDEADBEEF0BADF00D, 4, 1);

      // reset while a store sits in WAIT
      req[2].valid  = 1'b1;
      req[2].addr   = 64'h8000_0020;
      req[2].size   = MSIZE8;
      req[2].strobe = 8'hFF;
      req[2].data   = 64'h7777777777777777;
      @(posedge clk); #1;
      resetn = 1'b0;
      req[2].valid = 1'b0;
      #1;
      chk("rst_mid_addr_ok", 64'(resp[2].addr_ok), 64'd0);
      chk("rst_mid_data_ok", 64'(resp[2].data_ok), 64'd0);
      chk("rst_mid_data", resp[2].data, 64'd0);
      chk("rst_mid_err3", 64'(err[2]), 64'd0);
      chk("rst_mid_err1", 64'(err[0]), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      txn("rst_no_commit", 2, 64'h8000_0020, MSIZE8, 8'h00, 64'd0, 1, 64'hDEADBEEF0BADF00D, 4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Responder end of the data-bus (`dbus_req_t` / `dbus_resp_t`) handshake driven by the memory stage. It accepts one load or store at a time, waits a configurable number of cycles, then returns a full aligned 64-bit word (loads) or commits byte-strobed data (stores), pulsing `data_ok` for exactly one cycle. It is the on-chip data RAM for simulation and FPGA bring-up, and a latency-injecting stand-in for the cache/bus path when testing pipeline stalls.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: number of 64-bit words; power of two.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 1: wait cycles between acceptance and the response cycle; range 0..15.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `dreq`  in  `dbus_req_t`: `valid`, `addr`, `size` (`msize_t`), `strobe` (8 bits), `data` (64 bits, already lane-shifted by the initiator).
- `dresp`  out  `dbus_resp_t`: `addr_ok`, `data_ok`, and `data`, the full aligned 64-bit word.
- `err`  out  1: sticky error flag. Set by out-of-range, misaligned or abandoned requests; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `dreq.valid`=1:
  - Latch `addr`, `size`, `strobe`, `data`, and a write flag (`strobe`≠0).
  - Load the wait counter with `LATENCY`.
  - Next state is RESP if `LATENCY`=0, else WAIT.
- WAIT:
  - Decrement the counter each cycle; move to RESP when it reaches 0.
  - If `dreq.valid` drops, abort: go to IDLE, perform no write, set `err`.
- RESP:
  - Drive `addr_ok`=`data_ok`=1 for this one cycle.
  - Return to IDLE unconditionally.
  - Stores commit on the clock edge that ends RESP.
- Back-to-back requests: the memory stage advances in the RESP cycle. A `valid` seen in the following IDLE cycle is therefore a new request and is never a replay.
- Address decode:
  - Index = (`addr` − `BASE_ADDR`) >> 3, width $clog2(`DEPTH_WORDS`).
  - In range iff `BASE_ADDR` ≤ `addr` < `BASE_ADDR` + 8·`DEPTH_WORDS`. The comparison is 64-bit unsigned.
- Alignment: `addr[2:0]` must be a multiple of the access size (MSIZE1 any, MSIZE2 even, MSIZE4 multiple of 4, MSIZE8 zero).
- Out-of-range or misaligned request:
  - Still completes with normal timing.
  - `dresp.data` = 0, no write, `err` set at acceptance.
- Loads: `dresp.data` is the whole stored word regardless of `size`. The initiator extracts and extends the bytes it needs.
- Stores: byte lane i is written iff `strobe[i]`. Lanes with `strobe[i]`=0 are unchanged.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `addr_ok`=0, `data_ok`=0, `dresp.data`=0, `err`=0, counter 0.
- Reset asserted mid-transaction returns to IDLE immediately. A store still pending in WAIT or RESP is dropped; no partial write.
- Request accepted in cycle t → `data_ok` in cycle t+1+`LATENCY`.
  - Example: with `LATENCY`=1, `data_ok` arrives in cycle t+2 and the initiator stalls for cycles t..t+1.
- Throughput: one access per 2+`LATENCY` cycles.
- `dresp.data` is registered and valid only while `data_ok`=1. It is 0 in every other cycle.
- Read-after-write to the same word in consecutive transactions returns the new data, because the store commits before the next acceptance.
- `dreq` fields must stay stable from acceptance through RESP. Only the latched copy is used, so changes other than `valid` dropping have no effect.

## Structure
- `dbus_rsp_state_t` (IDLE/WAIT/RESP) goes in `common`, next to the existing dbus typedefs. `dbus_req_t`, `dbus_resp_t` and `msize_t` are reused unchanged.
- Sub-module `dbus_word_ram`:
  - `DEPTH_WORDS`×64 storage.
  - One read port, registered into `dresp.data` on entry to RESP.
  - One 8-lane byte-enable write port.
- The FSM, decode and error logic stay in `dbus_sram_responder`.

## Test plan
- `LATENCY`=1: store `addr`=0x8000_0010, `strobe`=0xFF, `data`=0x1122334455667788; then load the same address → each `data_ok` arrives 2 cycles after acceptance, and the load returns 0x1122334455667788.
- Byte store `addr`=0x8000_0013, `strobe`=0x08, `data`=0x00000000AB000000 over that word, then load → 0x11223344AB667788.
- `LATENCY`=0, two loads presented on consecutive accept opportunities → `data_ok` in cycles t+1 and t+3, with no duplicate response.
- Load `addr`=0x7FFF_FFF8 (out of range) and MSIZE4 at 0x8000_0002 (misaligned) → `data_ok` with data 0, `err`=1, and memory unchanged.
- `LATENCY`=3: store accepted, then `valid` dropped in the second WAIT cycle → no `data_ok`, FSM back in IDLE, `err`=1, target word unchanged.
- Assert `resetn`=0 during WAIT of a store → all outputs 0 immediately, state IDLE, store not committed.
